// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared widths, funct codes and FSM state type for the M-extension
// issue/writeback controller.
package muldiv_issue_ctrl_pkg;

   localparam int WD_SIZE       = 32;
   localparam int FUNCT7_SIZE   = 7;
   localparam int FUNCT3_SIZE   = 3;
   localparam int REG_ADDR_SIZE = 5;

   localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV = 7'b0000001;

   localparam logic [FUNCT3_SIZE-1:0] F3_MUL    = 3'b000;
   localparam logic [FUNCT3_SIZE-1:0] F3_MULH   = 3'b001;
   localparam logic [FUNCT3_SIZE-1:0] F3_MULHSU = 3'b010;
   localparam logic [FUNCT3_SIZE-1:0] F3_MULHU  = 3'b011;
   localparam logic [FUNCT3_SIZE-1:0] F3_DIV    = 3'b100;
   localparam logic [FUNCT3_SIZE-1:0] F3_DIVU   = 3'b101;
   localparam logic [FUNCT3_SIZE-1:0] F3_REM    = 3'b110;
   localparam logic [FUNCT3_SIZE-1:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      WB    = 2'd2,
      DRAIN = 2'd3
   } muldiv_state_t;

   function automatic logic is_div_rem(input logic [FUNCT3_SIZE-1:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_DIVU) ||
             (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

endpackage

// File: rtl/muldiv_issue_ctrl.sv
// Holds one M-extension op on the multiplier inputs, waits for its result
// and hands it to regfile writeback; divide-by-zero never reaches the unit.
module muldiv_issue_ctrl
   import muldiv_issue_ctrl_pkg::*;
#(
   parameter int MAX_LATENCY = 16,
   parameter int CNT_W       = $clog2(MAX_LATENCY + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [FUNCT7_SIZE-1:0]   req_funct7_i,
   input  logic [FUNCT3_SIZE-1:0]   req_funct3_i,
   input  logic [WD_SIZE-1:0]       req_rs1_data_i,
   input  logic [WD_SIZE-1:0]       req_rs2_data_i,
   input  logic [REG_ADDR_SIZE-1:0] req_rd_i,
   input  logic                     kill_i,
   output logic                     mul_op_o,
   output logic [FUNCT7_SIZE-1:0]   mul_funct7_o,
   output logic [FUNCT3_SIZE-1:0]   mul_funct3_o,
   output logic [WD_SIZE-1:0]       mul_op1_o,
   output logic [WD_SIZE-1:0]       mul_op2_o,
   input  logic                     mul_valid_i,
   input  logic [WD_SIZE-1:0]       mul_result_i,
   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output logic [REG_ADDR_SIZE-1:0] wb_rd_o,
   output logic [WD_SIZE-1:0]       wb_data_o,
   output logic                     stall_o,
   output logic                     timeout_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LATENCY);

   muldiv_state_t state, next_state;

   logic [CNT_W-1:0]         cnt;
   logic [FUNCT7_SIZE-1:0]   f7_q;
   logic [FUNCT3_SIZE-1:0]   f3_q;
   logic [WD_SIZE-1:0]       op1_q;
   logic [WD_SIZE-1:0]       op2_q;
   logic [REG_ADDR_SIZE-1:0] rd_q;
   logic [WD_SIZE-1:0]       wb_data_q;

   logic accept;
   logic bypass;
   logic cnt_max;

   // RISC-V x/0: quotient is all ones, remainder is the dividend
   function automatic logic [WD_SIZE-1:0] bypass_data(
      input logic [FUNCT3_SIZE-1:0] f3,
      input logic [WD_SIZE-1:0]     rs1
   );
      if (f3 == F3_REM || f3 == F3_REMU)
         return rs1;
      return '1;
   endfunction

   assign cnt_max = (cnt == CNT_MAX);
   assign accept  = (state == IDLE) && req_valid_i && !kill_i &&
                    (req_funct7_i == F7_MULDIV);
   assign bypass  = is_div_rem(req_funct3_i) && (req_rs2_data_i == '0);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (accept)
               next_state = bypass ? WB : BUSY;
         end
         BUSY: begin
            if (kill_i)
               next_state = DRAIN;
            else if (mul_valid_i || cnt_max)
               next_state = WB;
         end
         WB: begin
            if (kill_i || rd_q == '0 || wb_ready_i)
               next_state = IDLE;
         end
         DRAIN: begin
            if (mul_valid_i || cnt_max)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         f7_q      <= '0;
         f3_q      <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         rd_q      <= '0;
         wb_data_q <= '0;
      end else if (accept) begin
         cnt   <= '0;
         f7_q  <= req_funct7_i;
         f3_q  <= req_funct3_i;
         op1_q <= req_rs1_data_i;
         op2_q <= req_rs2_data_i;
         rd_q  <= req_rd_i;
         if (bypass)
            wb_data_q <= bypass_data(req_funct3_i, req_rs1_data_i);
      end else if (state == BUSY || state == DRAIN) begin
         if (!cnt_max)
            cnt <= cnt + CNT_W'(1);
         // valid result beats a coincident timeout
         if (state == BUSY && !kill_i) begin
            if (mul_valid_i)
               wb_data_q <= mul_result_i;
            else if (cnt_max)
               wb_data_q <= '0;
         end
      end
   end

   always_comb begin
      req_ready_o = 1'b0;
      mul_op_o    = 1'b0;
      wb_valid_o  = 1'b0;
      wb_rd_o     = '0;
      wb_data_o   = '0;
      stall_o     = (state != IDLE);
      timeout_o   = 1'b0;
      unique case (state)
         IDLE: req_ready_o = !kill_i && !reset;
         BUSY: begin
            mul_op_o  = 1'b1;
            timeout_o = cnt_max && !mul_valid_i && !kill_i;
         end
         WB: begin
            wb_valid_o = (rd_q != '0);
            wb_rd_o    = rd_q;
            wb_data_o  = wb_data_q;
         end
         DRAIN: ;
         default: ;
      endcase
   end

   assign mul_funct7_o = f7_q;
   assign mul_funct3_o = f3_q;
   assign mul_op1_o    = op1_q;
   assign mul_op2_o    = op2_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed and randomized bench for muldiv_issue_ctrl with a behavioural
// multiplier stub and a RISC-V M-extension arithmetic reference.
module tb_muldiv_issue_ctrl;
   import muldiv_issue_ctrl_pkg::*;

   logic        clk = 0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  req_f7;
   logic [2:0]  req_f3;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd;
   logic        kill;
   logic        mul_op;
   logic [6:0]  mul_f7;
   logic [2:0]  mul_f3;
   logic [31:0] mul_op1, mul_op2;
   logic        mul_valid;
   logic [31:0] mul_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall;
   logic        timeout;

   int checks   = 0;
   int failures = 0;

   muldiv_issue_ctrl #(.MAX_LATENCY(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_funct7_i   (req_f7),
      .req_funct3_i   (req_f3),
      .req_rs1_data_i (rs1),
      .req_rs2_data_i (rs2),
      .req_rd_i       (rd),
      .kill_i         (kill),
      .mul_op_o       (mul_op),
      .mul_funct7_o   (mul_f7),
      .mul_funct3_o   (mul_f3),
      .mul_op1_o      (mul_op1),
      .mul_op2_o      (mul_op2),
      .mul_valid_i    (mul_valid),
      .mul_result_i   (mul_result),
      .wb_valid_o     (wb_valid),
      .wb_ready_i     (wb_ready),
      .wb_rd_o        (wb_rd),
      .wb_data_o      (wb_data),
      .stall_o        (stall),
      .timeout_o      (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic [31:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (f3)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else begin p = ua / ub; r = p[31:0]; end
         end
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: begin
            if (b == 0) r = a;
            else begin p = ua % ub; r = p[31:0]; end
         end
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r);
      req_valid = 1;
      req_f7    = F7_MULDIV;
      req_f3    = f3;
      rs1       = a;
      rs2       = b;
      rd        = r;
      #1 chk("req_ready", req_ready, 1);
      step();
      req_valid = 0;
   endtask

   // full transaction: lat = BUSY cycles until the stub returns valid,
   // hold = cycles writeback back-pressures
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input int lat, input int hold);
      logic [31:0] exp;
      logic        byp;
      exp = ref_result(f3, a, b);
      byp = (f3 inside {3'd4, 3'd5, 3'd6, 3'd7}) && (b == 0);
      issue(f3, a, b, r);
      if (!byp) begin
         chk("mul_op_issue", mul_op, 1);
         chk("mul_op1", mul_op1, a);
         chk("mul_op2", mul_op2, b);
         chk("mul_f3", mul_f3, f3);
         chk("stall_busy", stall, 1);
         for (int i = 1; i < lat; i++) step();
         chk("mul_op_hold", mul_op, 1);
         mul_valid  = 1;
         mul_result = ref_result(mul_f3, mul_op1, mul_op2);
         step();
         mul_valid  = 0;
         mul_result = 0;
      end
      chk("mul_op_wb", mul_op, 0);
      chk("wb_valid", wb_valid, r != 0);
      if (r != 0) begin
         for (int i = 0; i < hold; i++) begin
            chk("wb_hold_data", wb_data, exp);
            step();
         end
         chk("wb_valid_hold", wb_valid, 1);
         chk("wb_data", wb_data, exp);
         chk("wb_rd", wb_rd, r);
         wb_ready = 1;
         step();
         wb_ready = 0;
      end else begin
         step();
      end
      chk("stall_idle", stall, 0);
      chk("wb_valid_idle", wb_valid, 0);
   endtask

   initial begin
      int pulses;
      int n;
      logic seen_wb;
      logic [31:0] a, b;

      reset = 1; req_valid = 0; req_f7 = F7_MULDIV; req_f3 = 0;
      rs1 = 0; rs2 = 0; rd = 0; kill = 0; mul_valid = 0;
      mul_result = 0; wb_ready = 0;
      step();
      step();
      chk("rst_ready", req_ready, 0);
      chk("rst_stall", stall, 0);
      chk("rst_mul_op", mul_op, 0);
      chk("rst_wb_valid", wb_valid, 0);
      reset = 0;
      #1 chk("rst_release_ready", req_ready, 1);

      do_op(F3_MUL, 7, 6, 5, 3, 0);
      do_op(F3_DIV, 100, 0, 3, 1, 0);
      do_op(F3_REMU, 100, 0, 4, 1, 0);
      do_op(F3_MUL, 9, 10, 7, 2, 4);

      // kill two cycles into BUSY, result arrives during DRAIN
      issue(F3_MUL, 5, 5, 2);
      step();
      kill = 1;
      step();
      kill = 0;
      chk("kill_mul_op", mul_op, 0);
      chk("kill_wb_valid", wb_valid, 0);
      chk("kill_stall", stall, 1);
      step();
      mul_valid = 1; mul_result = 25;
      step();
      mul_valid = 0; mul_result = 0;
      chk("drain_exit_stall", stall, 0);
      chk("drain_exit_ready", req_ready, 1);
      chk("drain_no_wb", wb_valid, 0);
      do_op(F3_MUL, 8, 11, 9, 2, 0);

      // kill right at BUSY entry, DRAIN ends on the latency bound
      issue(F3_MUL, 4, 4, 2);
      kill = 1;
      step();
      kill = 0;
      n = 0; pulses = 0; seen_wb = 0;
      while (stall && n < 40) begin
         if (timeout) pulses++;
         if (wb_valid) seen_wb = 1;
         step();
         n++;
      end
      chk("drain_bound_cycles", n, 16);
      chk("drain_no_timeout", pulses, 0);
      chk("drain_bound_no_wb", seen_wb, 0);

      // stuck multiplier
      issue(F3_MUL, 3, 3, 6);
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         if (timeout) pulses++;
         step();
      end
      chk("timeout_early", pulses, 0);
      chk("timeout_pulse", timeout, 1);
      step();
      chk("timeout_single", timeout, 0);
      chk("timeout_wb_valid", wb_valid, 1);
      chk("timeout_wb_data", wb_data, 0);
      chk("timeout_wb_rd", wb_rd, 6);
      wb_ready = 1;
      step();
      wb_ready = 0;
      chk("timeout_idle", stall, 0);

      // kill in IDLE blocks acceptance; non-M funct7 is ignored
      req_valid = 1; kill = 1; req_f3 = F3_MUL; rs1 = 2; rs2 = 2; rd = 1;
      #1 chk("kill_idle_ready", req_ready, 0);
      step();
      req_valid = 0; kill = 0;
      chk("kill_idle_stall", stall, 0);
      req_valid = 1; req_f7 = 7'b0100000;
      step();
      req_valid = 0;
      chk("non_m_stall", stall, 0);

      // kill during WB
      issue(F3_DIVU, 55, 0, 8);
      chk("wb_before_kill", wb_valid, 1);
      kill = 1;
      step();
      kill = 0;
      chk("wb_kill_valid", wb_valid, 0);
      chk("wb_kill_stall", stall, 0);

      do_op(F3_MUL, 2, 3, 0, 1, 0);

      // reset in the middle of BUSY
      issue(F3_MUL, 12, 12, 10);
      step();
      reset = 1;
      step();
      chk("midrst_mul_op", mul_op, 0);
      chk("midrst_wb_valid", wb_valid, 0);
      chk("midrst_wb_data", wb_data, 0);
      chk("midrst_stall", stall, 0);
      chk("midrst_timeout", timeout, 0);
      chk("midrst_op1", mul_op1, 0);
      reset = 0;
      #1 chk("midrst_ready", req_ready, 1);

      for (int i = 0; i < 100; i++) begin
         case ($urandom_range(0, 3))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 0;
            1: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         do_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)),
               $urandom_range(1, 6), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Issue/writeback controller placed directly upstream of the `multiplier` unit. It sits between the decode/issue stage and the regfile writeback port.
- Accepts one M-extension request at a time and holds operands and functs stable on the multiplier inputs. It then waits for `valid_result`, buffers the result with its destination register, and presents it to writeback.
- Stalls the front end while busy, handles pipeline kill, and short-circuits divide-by-zero per the RISC-V spec.

Parameters:
- `MAX_LATENCY`, 16: BUSY cycles allowed before timeout; also the DRAIN bound.
- `CNT_W`, `$clog2(MAX_LATENCY+1)`: latency counter width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: issue request valid.
- `req_ready_o` out 1: controller can accept.
- `req_funct7_i` in `FUNCT7_SIZE`: instruction funct7.
- `req_funct3_i` in `FUNCT3_SIZE`: instruction funct3.
- `req_rs1_data_i` in `WD_SIZE`: operand 1.
- `req_rs2_data_i` in `WD_SIZE`: operand 2.
- `req_rd_i` in `REG_ADDR_SIZE`: destination register.
- `kill_i` in 1: pipeline flush.
- `mul_op_o` out 1: drives multiplier `op_i`.
- `mul_funct7_o` out `FUNCT7_SIZE`: drives multiplier `funct7_i`.
- `mul_funct3_o` out `FUNCT3_SIZE`: drives multiplier `funct3_i`.
- `mul_op1_o` out `WD_SIZE`: drives multiplier `op1_data_i`.
- `mul_op2_o` out `WD_SIZE`: drives multiplier `op2_data_i`.
- `mul_valid_i` in 1: multiplier `valid_result_o`.
- `mul_result_i` in `WD_SIZE`: multiplier `result_o`.
- `wb_valid_o` out 1: writeback valid.
- `wb_ready_i` in 1: writeback accepts.
- `wb_rd_o` out `REG_ADDR_SIZE`: writeback destination.
- `wb_data_o` out `WD_SIZE`: writeback data.
- `stall_o` out 1: front-end stall; equals (state != IDLE).
- `timeout_o` out 1: one-cycle pulse when a BUSY operation times out.

Behaviour:
- **Reset:** one cycle of `reset`=1 forces state IDLE and counter 0. All outputs are 0 next cycle; `req_ready_o` is 1 after reset is released. Reset mid-operation aborts with no writeback.
- **States:** IDLE, BUSY, WB, DRAIN.
- **IDLE:**
  - `req_ready_o` = !`kill_i`.
  - On `req_valid_i` & `req_ready_o`: capture funct7, funct3, rs1, rs2 and rd.
  - funct7 != `F7_MULDIV`: capture nothing; stay IDLE.
  - Bypass case (funct3 in {DIV, DIVU, REM, REMU} and rs2 == 0): go directly to WB. Data is 32'hFFFF_FFFF for DIV/DIVU and rs1 for REM/REMU. No multiplier op is issued.
  - Otherwise go to BUSY with counter = 0.
- **BUSY:**
  - `mul_op_o` = 1 and `mul_*` outputs hold the captured values, stable every cycle.
  - Counter increments each cycle.
  - `mul_valid_i`=1: latch `mul_result_i` into `wb_data_o` and go to WB.
  - `mul_op_o` = 0 from the WB cycle on.
  - Counter == `MAX_LATENCY` without `mul_valid_i`: pulse `timeout_o`, set `wb_data_o` = 0, go to WB.
  - If `mul_valid_i` and timeout coincide, the valid result wins and there is no pulse.
- **WB:**
  - `wb_valid_o` = 1 with `wb_rd_o`/`wb_data_o` stable until `wb_ready_i`; then go to IDLE.
  - rd == 0: WB is skipped (`wb_valid_o` stays 0) and the state returns to IDLE from WB in one cycle.
- **Latency:** request accepted at cycle N → `mul_op_o` high at N+1 → `mul_valid_i` at cycle M → `wb_valid_o` at M+1. Bypass: `wb_valid_o` at N+1.
- **kill_i** has the highest priority:
  - IDLE: a concurrent request is not accepted.
  - BUSY: `mul_op_o` drops next cycle and the state goes to DRAIN.
  - WB: `wb_valid_o` drops next cycle and the state goes to IDLE.
  - DRAIN: ignored.
- **DRAIN:**
  - `mul_op_o` = 0 and the counter keeps running.
  - Exit to IDLE on `mul_valid_i` (result discarded) or counter == `MAX_LATENCY` (no `timeout_o` pulse).
- **Counter:** saturates at `MAX_LATENCY`; it never wraps.
- `req_ready_o` is 0 in all states other than IDLE; there is no overlap of requests.

Decomposition:
- **PARAMS_pkg additions:**
  - `REG_ADDR_SIZE` (5).
  - `F3_MULH`, `F3_MULHSU`, `F3_MULHU`, `F3_DIVU`, `F3_REM`, `F3_REMU` where absent.
  - `muldiv_state_t` enum {IDLE, BUSY, WB, DRAIN}.
- **Sub-modules:** none. The bypass result is a small function inside the module. The bench instantiates this block together with `multiplier`.

Test Plan:
1. MUL 7*6, rd=5, `wb_ready_i`=1 → `wb_valid_o` one cycle after `mul_valid_i`, `wb_rd_o`=5, `wb_data_o`=42; `stall_o` high from the accept cycle+1 until WB completes.
2. DIV 100/0 rd=3 → `wb_data_o`=32'hFFFF_FFFF at accept+1 and `mul_op_o` never rises. REMU 100/0 → `wb_data_o`=100.
3. MUL 9*10 with `wb_ready_i` held 0 for 4 cycles → `wb_valid_o`, `wb_data_o`=90 and `wb_rd_o` stay stable; state is IDLE the cycle after `wb_ready_i`=1.
4. `kill_i` 2 cycles into BUSY → `mul_op_o`=0 next cycle, no `wb_valid_o`, `req_ready_o`=1 after DRAIN ends. Next request 8*11 → 88.
5. Multiplier stubbed to never assert valid → `timeout_o` pulses once 16 cycles after BUSY entry, then `wb_valid_o` with data 0.
6. `reset` asserted mid-BUSY → all outputs 0 next cycle, no writeback; 100 random MUL/DIV pairs after reset all match the golden model.
